pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/load_use_detect.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller
//               (controller state encoding, register-index width, default
//               halt drain length).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   // Controller states: normal issue, draining after HALT, fully halted
   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } state_e;

   // Cycles a HALT needs after leaving ID before it has retired from WB
   localparam int unsigned DRAIN_CYCLES_DEF = 3;

   // Width of an architectural register index
   localparam int unsigned REG_W = 3;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use comparator. Flags when the instruction
//               in ID reads a register that a load currently in EX will write.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_mem_read_i,
   input  logic             ex_reg_write_i,
   input  logic [REG_W-1:0] ex_write_reg_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_rs_valid_i,
   input  logic             id_rt_valid_i,
   output logic             load_use_o
);

   logic rs_hit;
   logic rt_hit;

   // A source only matters when the instruction actually reads that field
   assign rs_hit     = id_rs_valid_i && (id_rs_i == ex_write_reg_i);
   assign rt_hit     = id_rt_valid_i && (id_rt_i == ex_write_reg_i);
   assign load_use_o = ex_mem_read_i && ex_reg_write_i && (rs_hit || rt_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and sequencing controller for the five-stage core.
//               Decodes stall/flush/bubble controls for PC, IF/ID, ID/EX and
//               EX/MEM, runs the HALT drain state machine and keeps a
//               saturating count of cycles spent stalling or flushing.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_rs_valid_i,
   input  logic             id_rt_valid_i,
   input  logic             id_halt_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_reg_write_i,
   input  logic [REG_W-1:0] ex_write_reg_i,
   input  logic             ex_branch_taken_i,
   input  logic             imem_stall_i,
   input  logic             dmem_stall_i,
   output logic             pc_hold_o,
   output logic             ifid_hold_o,
   output logic             ifid_flush_o,
   output logic             idex_hold_o,
   output logic             idex_zero_o,
   output logic             exmem_hold_o,
   output logic             halt_done_o,
   output logic [CNT_W-1:0] stall_count_o
);

   localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_e           state_q, state_d;
   logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] stall_count_q;

   logic load_use;
   logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_zero, exmem_hold, halt_done;
   logic any_ctrl;
   logic count_en;

   load_use_detect u_load_use_detect (
      .ex_mem_read_i  (ex_mem_read_i),
      .ex_reg_write_i (ex_reg_write_i),
      .ex_write_reg_i (ex_write_reg_i),
      .id_rs_i        (id_rs_i),
      .id_rt_i        (id_rt_i),
      .id_rs_valid_i  (id_rs_valid_i),
      .id_rt_valid_i  (id_rt_valid_i),
      .load_use_o     (load_use)
   );

   // Output decode and next-state logic; dmem_stall freezes everything so it
   // always takes precedence over any other event in RUN and DRAIN
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_hold   = 1'b0;
      idex_zero   = 1'b0;
      exmem_hold  = 1'b0;
      halt_done   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (dmem_stall_i) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               idex_hold  = 1'b1;
               exmem_hold = 1'b1;
            end else if (ex_branch_taken_i) begin
               // Kills the two younger instructions, including a HALT in ID
               ifid_flush = 1'b1;
               idex_zero  = 1'b1;
            end else if (load_use) begin
               pc_hold   = 1'b1;
               ifid_hold = 1'b1;
               idex_zero = 1'b1;
            end else if (imem_stall_i) begin
               pc_hold    = 1'b1;
               ifid_flush = 1'b1;
            end else if (id_halt_i) begin
               pc_hold     = 1'b1;
               ifid_flush  = 1'b1;
               state_d     = ST_DRAIN;
               drain_cnt_d = DW'(DRAIN_CYCLES);
            end
         end
         ST_DRAIN: begin
            if (dmem_stall_i) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               idex_hold  = 1'b1;
               exmem_hold = 1'b1;
            end else begin
               pc_hold     = 1'b1;
               ifid_flush  = 1'b1;
               drain_cnt_d = drain_cnt_q - DW'(1);
               if (drain_cnt_q <= DW'(1)) begin
                  state_d = ST_HALTED;
               end
            end
         end
         ST_HALTED: begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            halt_done  = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign any_ctrl = pc_hold | ifid_hold | ifid_flush | idex_hold | idex_zero | exmem_hold;
   assign count_en = (state_q != ST_HALTED) && any_ctrl && (stall_count_q != {CNT_W{1'b1}});

   // Controller state and drain counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Saturating count of cycles with any hold, flush or bubble active
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_count_q <= '0;
      end else if (count_en) begin
         stall_count_q <= stall_count_q + CNT_W'(1);
      end
   end

   // Controls are forced low for as long as reset is held
   assign pc_hold_o     = rst_ni & pc_hold;
   assign ifid_hold_o   = rst_ni & ifid_hold;
   assign ifid_flush_o  = rst_ni & ifid_flush;
   assign idex_hold_o   = rst_ni & idex_hold;
   assign idex_zero_o   = rst_ni & idex_zero;
   assign exmem_hold_o  = rst_ni & exmem_hold;
   assign halt_done_o   = rst_ni & halt_done;
   assign stall_count_o = stall_count_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Two instances share
//               one stimulus: the default 16-bit counter and a 4-bit counter
//               that exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] id_rs, id_rt, ex_write_reg;
   logic       id_rs_valid, id_rt_valid, id_halt;
   logic       ex_mem_read, ex_reg_write, ex_branch_taken, imem_stall, dmem_stall;

   logic pc_a, ifh_a, iff_a, idh_a, idz_a, emh_a, hd_a;
   logic pc_b, ifh_b, iff_b, idh_b, idz_b, emh_b, hd_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   logic [6:0]  out_a, out_b;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: halted flag, cycles left to drain, raw stall cycles
   bit     m_halted;
   int     m_drain_left;
   longint m_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_rs_valid_i(id_rs_valid), .id_rt_valid_i(id_rt_valid),
      .id_halt_i(id_halt), .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
      .ex_write_reg_i(ex_write_reg), .ex_branch_taken_i(ex_branch_taken),
      .imem_stall_i(imem_stall), .dmem_stall_i(dmem_stall),
      .pc_hold_o(pc_a), .ifid_hold_o(ifh_a), .ifid_flush_o(iff_a),
      .idex_hold_o(idh_a), .idex_zero_o(idz_a), .exmem_hold_o(emh_a),
      .halt_done_o(hd_a), .stall_count_o(cnt_a)
   );

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_rs_valid_i(id_rs_valid), .id_rt_valid_i(id_rt_valid),
      .id_halt_i(id_halt), .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
      .ex_write_reg_i(ex_write_reg), .ex_branch_taken_i(ex_branch_taken),
      .imem_stall_i(imem_stall), .dmem_stall_i(dmem_stall),
      .pc_hold_o(pc_b), .ifid_hold_o(ifh_b), .ifid_flush_o(iff_b),
      .idex_hold_o(idh_b), .idex_zero_o(idz_b), .exmem_hold_o(emh_b),
      .halt_done_o(hd_b), .stall_count_o(cnt_b)
   );

   // Output vector order: {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_zero, exmem_hold, halt_done}
   assign out_a = {pc_a, ifh_a, iff_a, idh_a, idz_a, emh_a, hd_a};
   assign out_b = {pc_b, ifh_b, iff_b, idh_b, idz_b, emh_b, hd_b};

   typedef struct {
      string      name;
      logic [2:0] rs, rt, wr;
      logic       rsv, rtv, halt, mr, rw, br, im, dm;
      logic [6:0] exp_out;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(string name, logic [2:0] rs, logic rsv, logic [2:0] rt, logic rtv,
                               logic mr, logic rw, logic [2:0] wr, logic br, logic im, logic dm,
                               logic halt, logic [6:0] exp_out, int exp_cnt);
      vec_t v;
      v.name = name; v.rs = rs; v.rsv = rsv; v.rt = rt; v.rtv = rtv;
      v.mr = mr; v.rw = rw; v.wr = wr; v.br = br; v.im = im; v.dm = dm;
      v.halt = halt; v.exp_out = exp_out; v.exp_cnt = exp_cnt;
      return v;
   endfunction

   task automatic check(string name, longint act, longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sat(longint c, int w);
      longint mx = (longint'(1) << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   // Expected controls from the rules, evaluated on the current inputs
   function automatic logic [6:0] model_out();
      bit lu;
      lu = ex_mem_read && ex_reg_write &&
           ((id_rs_valid && id_rs == ex_write_reg) || (id_rt_valid && id_rt == ex_write_reg));
      if (m_halted)              return 7'b1101011;
      else if (dmem_stall)       return 7'b1101010;
      else if (m_drain_left > 0) return 7'b1010000;
      else if (ex_branch_taken)  return 7'b0010100;
      else if (lu)               return 7'b1100100;
      else if (imem_stall)       return 7'b1010000;
      else if (id_halt)          return 7'b1010000;
      return 7'b0000000;
   endfunction

   // Advance the model across one clock edge
   task automatic model_step(logic [6:0] e);
      bit lu;
      lu = ex_mem_read && ex_reg_write &&
           ((id_rs_valid && id_rs == ex_write_reg) || (id_rt_valid && id_rt == ex_write_reg));
      if (m_halted) return;
      if (e[6:1] != 6'b0) m_cnt++;
      if (dmem_stall) return;
      if (m_drain_left > 0) begin
         m_drain_left--;
         if (m_drain_left == 0) m_halted = 1'b1;
      end else if (!ex_branch_taken && !lu && !imem_stall && id_halt) begin
         m_drain_left = 3;
      end
   endtask

   task automatic model_reset();
      m_halted = 1'b0; m_drain_left = 0; m_cnt = 0;
   endtask

   task automatic zero_inputs();
      id_rs = '0; id_rt = '0; ex_write_reg = '0; id_rs_valid = 0; id_rt_valid = 0;
      id_halt = 0; ex_mem_read = 0; ex_reg_write = 0; ex_branch_taken = 0;
      imem_stall = 0; dmem_stall = 0;
   endtask

   // One cycle: compare both instances at the falling edge, then clock the model
   task automatic cycle();
      logic [6:0] e;
      @(negedge clk);
      e = model_out();
      check("outs_a", out_a, e);
      check("outs_b", out_b, e);
      check("cnt_a", cnt_a, sat(m_cnt, 16));
      check("cnt_b", cnt_b, sat(m_cnt, 4));
      @(posedge clk);
      model_step(e);
      #1;
   endtask

   // Called just after a rising edge; asserts reset asynchronously and
   // checks that every output is forced low regardless of inputs
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_outs_a", out_a, 0);
      check("rst_outs_b", out_b, 0);
      check("rst_cnt_a", cnt_a, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   int lat;

   initial begin
      rst_n = 1'b0;
      zero_inputs();
      model_reset();
      @(posedge clk);
      #1;

      // ---------------- table-driven single-cycle decode from RUN --------
      //             name          rs  rsv rt  rtv mr rw wr  br im dm halt  out          cnt
      vecs[0]  = mk("idle",        0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0,  7'b0000000, 0);
      vecs[1]  = mk("lu_rs",       3, 1,  0, 0,  1, 1, 3,  0, 0, 0, 0,  7'b1100100, 1);
      vecs[2]  = mk("lu_novalid",  3, 0,  3, 0,  1, 1, 3,  0, 0, 0, 0,  7'b0000000, 0);
      vecs[3]  = mk("lu_rt",       3, 1,  5, 1,  1, 1, 5,  0, 0, 0, 0,  7'b1100100, 1);
      vecs[4]  = mk("no_regwr",    3, 1,  3, 1,  1, 0, 3,  0, 0, 0, 0,  7'b0000000, 0);
      vecs[5]  = mk("no_match",    2, 1,  4, 1,  1, 1, 3,  0, 0, 0, 0,  7'b0000000, 0);
      vecs[6]  = mk("br_lu_halt",  3, 1,  0, 0,  1, 1, 3,  1, 0, 0, 1,  7'b0010100, 1);
      vecs[7]  = mk("dm_br",       0, 0,  0, 0,  0, 0, 0,  1, 0, 1, 0,  7'b1101010, 1);
      vecs[8]  = mk("imem",        0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 0,  7'b1010000, 1);
      vecs[9]  = mk("halt",        0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 1,  7'b1010000, 1);
      vecs[10] = mk("lu_imem",     1, 1,  0, 0,  1, 1, 1,  0, 1, 0, 0,  7'b1100100, 1);
      vecs[11] = mk("dm_lu_halt",  1, 1,  0, 0,  1, 1, 1,  0, 1, 1, 1,  7'b1101010, 1);

      for (int i = 0; i < 12; i++) begin
         do_reset();
         id_rs = vecs[i].rs; id_rs_valid = vecs[i].rsv;
         id_rt = vecs[i].rt; id_rt_valid = vecs[i].rtv;
         ex_mem_read = vecs[i].mr; ex_reg_write = vecs[i].rw; ex_write_reg = vecs[i].wr;
         ex_branch_taken = vecs[i].br; imem_stall = vecs[i].im; dmem_stall = vecs[i].dm;
         id_halt = vecs[i].halt;
         @(negedge clk);
         check({"vec_out_", vecs[i].name}, out_a, vecs[i].exp_out);
         @(posedge clk);
         #1;
         check({"vec_cnt_", vecs[i].name}, cnt_a, vecs[i].exp_cnt);
         zero_inputs();
      end

      // ---------------- branch+load_use+halt kills HALT: no drain --------
      do_reset();
      id_rs = 3; id_rs_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 3;
      ex_branch_taken = 1; id_halt = 1;
      cycle();
      zero_inputs();
      cycle();
      check("br_kills_halt_idle", out_a, 0);

      // ---------------- dmem_stall x4 with branch held, flush in cycle 5 --
      do_reset();
      ex_branch_taken = 1; dmem_stall = 1;
      for (int i = 0; i < 4; i++) cycle();
      dmem_stall = 0;
      cycle();
      zero_inputs();
      cycle();
      check("dm_br_count", cnt_a, 5);

      // ---------------- halt with one dmem_stall during drain ------------
      do_reset();
      id_halt = 1;
      lat = -1;
      for (int t = 0; t < 12; t++) begin
         if (t != 0) id_halt = 0;
         dmem_stall = (t == 2);
         if (hd_a && lat < 0) lat = t;
         cycle();
      end
      check("halt_latency", lat, 5);
      check("halt_done_held", hd_a, 1);
      // async reset pulse from HALTED, released before the next edge
      rst_n = 1'b0;
      #1;
      check("halt_rst_async", hd_a, 0);
      #1;
      rst_n = 1'b1;
      model_reset();
      zero_inputs();
      cycle();
      check("post_rst_run", out_a, 0);

      // ---------------- reset in the middle of DRAIN ---------------------
      do_reset();
      id_halt = 1;
      cycle();
      id_halt = 0;
      cycle();
      do_reset();
      cycle();
      check("mid_drain_rst", out_a, 0);

      // ---------------- saturation: 2^4+2 stall cycles -------------------
      do_reset();
      imem_stall = 1;
      for (int i = 0; i < 18; i++) cycle();
      imem_stall = 0;
      cycle();
      check("sat_cnt_b", cnt_b, 15);
      check("sat_cnt_a", cnt_a, 18);

      // ---------------- randomized stimulus against the model ------------
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         id_rs           = 3'($urandom_range(0, 3));
         id_rt           = 3'($urandom_range(0, 3));
         ex_write_reg    = 3'($urandom_range(0, 3));
         id_rs_valid     = ($urandom_range(0, 3) != 0);
         id_rt_valid     = ($urandom_range(0, 1) != 0);
         ex_mem_read     = ($urandom_range(0, 2) == 0);
         ex_reg_write    = ($urandom_range(0, 3) != 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         imem_stall      = ($urandom_range(0, 5) == 0);
         dmem_stall      = ($urandom_range(0, 7) == 0);
         id_halt         = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 7) == 0))
            do_reset();
         else
            cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
